// File: rtl/line_pixel_iter.sv
// Bresenham iteration stage: walks the major axis from x0 to x1 and emits one
// screen pixel per pix_valid/pix_ready handshake, un-swapping axes for steep lines.
module line_pixel_iter #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y0,
  input  logic             steep,
  input  logic [WIDTH-1:0] deltax,
  input  logic [WIDTH-1:0] deltay,
  input  logic [WIDTH-1:0] ystep,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [WIDTH-1:0] pix_x,
  output logic [WIDTH-1:0] pix_y,
  output logic             line_done,
  output logic             dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never drops and its data never changes until that edge.

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state_q;
  logic [WIDTH-1:0]        x_q, y_q, x_end_q, dx_q, dy_q, ystep_q;
  logic                    steep_q;
  logic signed [WIDTH:0]   err_q;
  logic                    in_ready_q, pix_valid_q, line_done_q;
  logic [WIDTH-1:0]        pix_x_q, pix_y_q;

  logic signed [WIDTH:0]   e_d, err_d;
  logic [WIDTH-1:0]        x_d, y_d;

  // Next major/minor step, used only when a pixel is accepted mid-line.
  always_comb begin
    e_d   = err_q - $signed({1'b0, dy_q});
    x_d   = x_q + WIDTH'(1);
    y_d   = y_q;
    err_d = e_d;
    if (e_d[WIDTH]) begin
      y_d   = y_q + ystep_q;
      err_d = e_d + $signed({1'b0, dx_q});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      x_end_q     <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      ystep_q     <= '0;
      steep_q     <= 1'b0;
      err_q       <= '0;
      in_ready_q  <= 1'b1;
      pix_valid_q <= 1'b0;
      line_done_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
    end else begin
      line_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q         <= x0;
            y_q         <= y0;
            x_end_q     <= x1;
            dx_q        <= deltax;
            dy_q        <= deltay;
            ystep_q     <= ystep;
            steep_q     <= steep;
            err_q       <= $signed({deltax[WIDTH-1], deltax}) >>> 1;
            state_q     <= RUN;
            in_ready_q  <= 1'b0;
            pix_valid_q <= 1'b1;
            pix_x_q     <= steep ? y0 : x0;
            pix_y_q     <= steep ? x0 : y0;
          end
        end
        RUN: begin
          if (pix_ready) begin
            if (x_q == x_end_q) begin
              state_q     <= IDLE;
              in_ready_q  <= 1'b1;
              pix_valid_q <= 1'b0;
              line_done_q <= 1'b1;
            end else begin
              x_q     <= x_d;
              y_q     <= y_d;
              err_q   <= err_d;
              pix_x_q <= steep_q ? y_d : x_d;
              pix_y_q <= steep_q ? x_d : y_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign line_done   = line_done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_line_pixel_iter.sv
// Directed bench for line_pixel_iter: hand-computed pixel lists fed to a
// scoreboard queue, with hold, latency, line_done and reset checks.
module tb_line_pixel_iter;
  localparam int W = 13;

  logic         clk, rst, in_valid, in_ready, steep, pix_valid, pix_ready, line_done, dbg_state;
  logic [W-1:0] x0, x1, y0, deltax, deltay, ystep, pix_x, pix_y;

  int n_checks = 0;
  int n_fail   = 0;

  // Bit 2W marks the last pixel of a line; low bits are {x, y}.
  logic [2*W:0]   exp_q[$];
  logic           done_pend = 1'b0;
  logic           hold_pend = 1'b0;
  logic [2*W-1:0] held;
  logic           bp_mode = 1'b0;
  int             bp_cnt  = 0;

  line_pixel_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .x1(x1), .y0(y0), .steep(steep), .deltax(deltax), .deltay(deltay),
    .ystep(ystep), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .line_done(line_done), .dbg_state_o(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      done_pend = 1'b0;
      hold_pend = 1'b0;
    end else begin
      check("line_done", 64'(line_done), 64'(done_pend));
      check("in_ready", 64'(in_ready), 64'(!pix_valid));
      done_pend = 1'b0;
      if (hold_pend) begin
        check("hold_valid", 64'(pix_valid), 64'd1);
        check("hold_pix", 64'({pix_x, pix_y}), 64'(held));
      end
      hold_pend = 1'b0;
      if (pix_valid) begin
        if (pix_ready) begin
          if (exp_q.size() == 0) begin
            check("pix_extra", 64'(exp_q.size()), 64'd1);
          end else begin
            logic [2*W:0] e;
            e = exp_q.pop_front();
            check("pix", 64'({pix_x, pix_y}), 64'(e[2*W-1:0]));
            done_pend = e[2*W];
          end
        end else begin
          hold_pend = 1'b1;
          held      = {pix_x, pix_y};
        end
      end
    end
  end

  // pix_ready driver: pattern 1,0,0 repeating when backpressure is on
  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      pix_ready = (bp_cnt % 3 == 0);
      bp_cnt++;
    end
  end

  task automatic push_pix(input int x, input int y, input logic last);
    exp_q.push_back({last, W'(x), W'(y)});
  endtask

  task automatic start_line(input int ax0, input int ax1, input int ay0, input logic ast,
                            input int adx, input int ady, input int ays);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    x0 = W'(ax0); x1 = W'(ax1); y0 = W'(ay0); steep = ast;
    deltax = W'(adx); deltay = W'(ady); ystep = W'(ays);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("first_valid", 64'(pix_valid), 64'd1);
  endtask

  // Called right after start_line; returns cycles from first pixel to line_done.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!line_done && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
    check("done_seen", 64'(line_done), 64'd1);
  endtask

  task automatic shallow_exp();
    push_pix(0, 0, 0); push_pix(1, 0, 0); push_pix(2, 1, 0);
    push_pix(3, 1, 0); push_pix(4, 2, 1);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; in_valid = 1'b0; pix_ready = 1'b1;
    x0 = '0; x1 = '0; y0 = '0; steep = 1'b0; deltax = '0; deltay = '0; ystep = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_pix_valid", 64'(pix_valid), 64'd0);
    check("rst_pix", 64'({pix_x, pix_y}), 64'd0);
    check("rst_line_done", 64'(line_done), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;

    // Shallow line, full throughput
    shallow_exp();
    start_line(0, 4, 0, 1'b0, 4, 2, 1);
    wait_done(cyc);
    check("shallow_cycles", 64'(cyc), 64'd5);

    // Steep line
    push_pix(0, 0, 0); push_pix(0, 1, 0); push_pix(1, 2, 0);
    push_pix(1, 3, 0); push_pix(2, 4, 0); push_pix(2, 5, 1);
    start_line(0, 5, 0, 1'b1, 5, 2, 1);
    wait_done(cyc);
    check("steep_cycles", 64'(cyc), 64'd6);

    // Negative ystep
    push_pix(0, 3, 0); push_pix(1, 2, 0); push_pix(2, 1, 0); push_pix(3, 0, 1);
    start_line(0, 3, 3, 1'b0, 3, 3, -1);
    wait_done(cyc);
    check("neg_cycles", 64'(cyc), 64'd4);

    // Degenerate line with a stray in_valid pulse while running
    push_pix(7, 9, 1);
    @(posedge clk); #1 pix_ready = 1'b0;
    start_line(7, 7, 9, 1'b0, 0, 0, 0);
    x0 = W'(1); x1 = W'(3); y0 = W'(2); deltax = W'(2); in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 pix_ready = 1'b1;
    wait_done(cyc);
    repeat (4) @(negedge clk);
    check("degen_state", 64'(dbg_state), 64'd0);
    check("degen_queue", 64'(exp_q.size()), 64'd0);

    // Backpressure: pix_ready 1,0,0,1,...
    shallow_exp();
    bp_cnt = 0; bp_mode = 1'b1;
    start_line(0, 4, 0, 1'b0, 4, 2, 1);
    wait_done(cyc);
    bp_mode = 1'b0;
    @(posedge clk); #1 pix_ready = 1'b1;
    check("bp_queue", 64'(exp_q.size()), 64'd0);

    // Reset after the second pixel is accepted
    shallow_exp();
    start_line(0, 4, 0, 1'b0, 4, 2, 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_pix_valid", 64'(pix_valid), 64'd0);
    check("mid_rst_pix", 64'({pix_x, pix_y}), 64'd0);
    check("mid_rst_line_done", 64'(line_done), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_hold_line_done", 64'(line_done), 64'd0);
    end
    rst = 1'b0;
    shallow_exp();
    start_line(0, 4, 0, 1'b0, 4, 2, 1);
    wait_done(cyc);
    check("post_rst_cycles", 64'(cyc), 64'd5);
    repeat (3) @(negedge clk);
    check("final_queue", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
